// File: rtl/mpx_hilo_sched.sv
// HI/LO scheduler for the MPX multiply/divide unit: owns HI/LO, tracks one outstanding MUL/DIV.
// Optional MPX_HILO_ABORT_EN: R3000-style issue (abort/drop instead of stall while busy).
module mpx_hilo_sched #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        hold_i,
  input  logic        issue_valid_i,
  input  logic [2:0]  issue_op_i,
  input  logic [31:0] issue_data_i,
  output logic        issue_stall_o,
  output logic [31:0] mf_data_o,
  input  logic        mul_valid_i,
  input  logic [31:0] mul_hi_i,
  input  logic [31:0] mul_lo_i,
  output logic        div_start_o,
  output logic        div_abort_o,
  input  logic        div_valid_i,
  input  logic [31:0] div_hi_i,
  input  logic [31:0] div_lo_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [2:0] OP_MUL  = 3'd1;
  localparam logic [2:0] OP_DIV  = 3'd2;
  localparam logic [2:0] OP_MTHI = 3'd3;
  localparam logic [2:0] OP_MTLO = 3'd4;
  localparam logic [2:0] OP_MFHI = 3'd5;
  localparam logic [2:0] OP_MFLO = 3'd6;

  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT} state_e;

  state_e        state_q, state_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          validOp, isMf, busy, mulHit, divHit, arrive, accept, dropActive;
  logic [31:0]   arrHi, arrLo;

`ifdef MPX_HILO_ABORT_EN
  logic [1:0] drop_q, drop_d;
  logic       dropInc, dropDec;
  assign dropActive = (drop_q != 2'd0);
`else
  assign dropActive = 1'b0;
`endif

  always_comb begin
    validOp = (issue_op_i != 3'd0) && (issue_op_i != 3'd7);
    isMf    = (issue_op_i == OP_MFHI) || (issue_op_i == OP_MFLO);
    busy    = (state_q != IDLE);
    mulHit  = (state_q == MUL_WAIT) && mul_valid_i && !dropActive;
    divHit  = (state_q == DIV_WAIT) && div_valid_i;
    arrive  = mulHit || divHit;
    arrHi   = mulHit ? mul_hi_i : div_hi_i;
    arrLo   = mulHit ? mul_lo_i : div_lo_i;
`ifdef MPX_HILO_ABORT_EN
    issue_stall_o = issue_valid_i && isMf && busy && !arrive;
`else
    issue_stall_o = issue_valid_i && validOp && busy && !arrive;
`endif
    accept = issue_valid_i && validOp && !issue_stall_o && !hold_i;
    if (issue_op_i == OP_MFHI) mf_data_o = arrive ? arrHi : hi_q;
    else                       mf_data_o = arrive ? arrLo : lo_q;
  end

  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    div_start_o = 1'b0;
    div_abort_o = 1'b0;
`ifdef MPX_HILO_ABORT_EN
    drop_d  = drop_q;
    dropInc = 1'b0;
    dropDec = mul_valid_i && dropActive;
`endif

    // Timeout counter saturates at TIMEOUT so err_o fires exactly once and stays sticky.
    if (busy && !hold_i && !arrive && (cnt_q != CW'(TIMEOUT))) begin
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(TIMEOUT - 1)) err_d = 1'b1;
    end

    if (mul_valid_i && (state_q != MUL_WAIT) && !dropActive) err_d = 1'b1;
    if (div_valid_i && (state_q != DIV_WAIT)) err_d = 1'b1;

    if (arrive) begin
      state_d = IDLE;
      hi_d    = arrHi;
      lo_d    = arrLo;
    end

`ifdef MPX_HILO_ABORT_EN
    // Non-MF issue while an op is still in flight cancels it: abort the divider or drop the product.
    if (accept && !isMf && busy && !arrive) begin
      state_d = IDLE;
      if (state_q == DIV_WAIT) div_abort_o = 1'b1;
      else                     dropInc     = 1'b1;
    end
`endif

    if (accept) begin
      case (issue_op_i)
        OP_MUL: begin
          state_d = MUL_WAIT;
          cnt_d   = '0;
        end
        OP_DIV: begin
          state_d     = DIV_WAIT;
          cnt_d       = '0;
          div_start_o = 1'b1;
        end
        OP_MTHI: hi_d = issue_data_i;
        OP_MTLO: lo_d = issue_data_i;
        default: ;
      endcase
    end

`ifdef MPX_HILO_ABORT_EN
    if (dropInc && !dropDec && (drop_q != 2'd3)) drop_d = drop_q + 2'd1;
    else if (dropDec && !dropInc)                drop_d = drop_q - 2'd1;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
`ifdef MPX_HILO_ABORT_EN
      drop_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`ifdef MPX_HILO_ABORT_EN
      drop_q  <= drop_d;
`endif
    end
  end

  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
  assign busy_o = busy;
  assign err_o  = err_q;

endmodule

// File: tb/tb_mpx_hilo_sched.sv
// Directed self-checking bench for mpx_hilo_sched, built with TIMEOUT=4 so timeouts are reachable.
module tb_mpx_hilo_sched;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        hold_i;
  logic        issue_valid_i;
  logic [2:0]  issue_op_i;
  logic [31:0] issue_data_i;
  logic        issue_stall_o;
  logic [31:0] mf_data_o;
  logic        mul_valid_i;
  logic [31:0] mul_hi_i, mul_lo_i;
  logic        div_start_o, div_abort_o;
  logic        div_valid_i;
  logic [31:0] div_hi_i, div_lo_i;
  logic [31:0] hi_o, lo_o;
  logic        busy_o, err_o;

  int checks = 0;
  int passes = 0;
  int stallCount;

  mpx_hilo_sched #(.TIMEOUT(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .hold_i(hold_i),
    .issue_valid_i(issue_valid_i), .issue_op_i(issue_op_i), .issue_data_i(issue_data_i),
    .issue_stall_o(issue_stall_o), .mf_data_o(mf_data_o),
    .mul_valid_i(mul_valid_i), .mul_hi_i(mul_hi_i), .mul_lo_i(mul_lo_i),
    .div_start_o(div_start_o), .div_abort_o(div_abort_o),
    .div_valid_i(div_valid_i), .div_hi_i(div_hi_i), .div_lo_i(div_lo_i),
    .hi_o(hi_o), .lo_o(lo_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [31:0] d);
    issue_valid_i = v;
    issue_op_i    = op;
    issue_data_i  = d;
  endtask

  task automatic quiet();
    applyStimulus(1'b0, 3'd0, 32'h0);
    mul_valid_i = 1'b0;
    div_valid_i = 1'b0;
    hold_i      = 1'b0;
  endtask

  // Advance one cycle; inputs change and outputs are sampled at the falling edge.
  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic doReset();
    rst_ni = 1'b0;
    #2;
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  initial begin
    quiet();
    mul_hi_i = 0; mul_lo_i = 0; div_hi_i = 0; div_lo_i = 0;
    rst_ni = 1'b0;
    #1;
    checkOutput("rst_hi", hi_o, 32'h0);
    checkOutput("rst_lo", lo_o, 32'h0);
    checkOutput("rst_busy", {31'b0, busy_o}, 32'h0);
    checkOutput("rst_err", {31'b0, err_o}, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Test 1: MUL, result two cycles later
    applyStimulus(1'b1, 3'd1, 32'h0);
    #1 checkOutput("t1_stall", {31'b0, issue_stall_o}, 32'h0);
    step();
    quiet();
    checkOutput("t1_busy", {31'b0, busy_o}, 32'h1);
    applyStimulus(1'b1, 3'd7, 32'h0);
    #1 checkOutput("t1_op7_nostall", {31'b0, issue_stall_o}, 32'h0);
    step();
    quiet();
    mul_valid_i = 1'b1; mul_hi_i = 32'h1; mul_lo_i = 32'h2;
    step();
    quiet();
    checkOutput("t1_hi", hi_o, 32'h1);
    checkOutput("t1_lo", lo_o, 32'h2);
    checkOutput("t1_busy_fall", {31'b0, busy_o}, 32'h0);
    checkOutput("t1_err", {31'b0, err_o}, 32'h0);

    // Test 3: MTHI then forwarded MFHI; MTLO then MFLO
    applyStimulus(1'b1, 3'd3, 32'hDEAD);
    step();
    applyStimulus(1'b1, 3'd5, 32'h0);
    #1;
    checkOutput("t3_stall", {31'b0, issue_stall_o}, 32'h0);
    checkOutput("t3_mfhi", mf_data_o, 32'hDEAD);
    step();
    applyStimulus(1'b1, 3'd4, 32'h1234);
    step();
    applyStimulus(1'b1, 3'd6, 32'h0);
    #1 checkOutput("t3_mflo", mf_data_o, 32'h1234);
    step();
    quiet();

    // Hold while IDLE blocks acceptance of MTLO
    hold_i = 1'b1;
    applyStimulus(1'b1, 3'd4, 32'h5555);
    #1 checkOutput("hold_nostall", {31'b0, issue_stall_o}, 32'h0);
    step();
    quiet();
    checkOutput("hold_noaccept", lo_o, 32'h1234);

    // Test 2: DIV, MFLO stalls 34 cycles, forwarded in arrive cycle (TIMEOUT=4 -> err)
    applyStimulus(1'b1, 3'd2, 32'h0);
    #1 checkOutput("t2_divstart", {31'b0, div_start_o}, 32'h1);
    step();
    applyStimulus(1'b1, 3'd6, 32'h0);
    stallCount = 0;
    for (int i = 0; i < 34; i++) begin
      #1 if (issue_stall_o) stallCount++;
      step();
    end
    checkOutput("t2_stallcnt", stallCount, 34);
    div_valid_i = 1'b1; div_hi_i = 32'h77; div_lo_i = 32'hCAFE;
    #1;
    checkOutput("t2_arrive_nostall", {31'b0, issue_stall_o}, 32'h0);
    checkOutput("t2_fwd", mf_data_o, 32'hCAFE);
    step();
    quiet();
    checkOutput("t2_lo", lo_o, 32'hCAFE);
    checkOutput("t2_hi", hi_o, 32'h77);
    checkOutput("t2_busy", {31'b0, busy_o}, 32'h0);
    checkOutput("t2_timeout_err", {31'b0, err_o}, 32'h1);
    doReset();
    checkOutput("t2_err_cleared", {31'b0, err_o}, 32'h0);

    // Test 4: long hold during MUL_WAIT does not advance timeout
    applyStimulus(1'b1, 3'd1, 32'h0);
    step();
    quiet();
    hold_i = 1'b1;
    for (int i = 0; i < 10; i++) step();
    hold_i = 1'b0;
    step();
    step();
    mul_valid_i = 1'b1; mul_hi_i = 32'hAA; mul_lo_i = 32'hBB;
    step();
    quiet();
    checkOutput("t4_err", {31'b0, err_o}, 32'h0);
    checkOutput("t4_hi", hi_o, 32'hAA);
    checkOutput("t4_lo", lo_o, 32'hBB);

    // Timeout boundary: 3 wait cycles no error, 4th sets it
    applyStimulus(1'b1, 3'd1, 32'h0);
    step();
    quiet();
    step(); step(); step();
    checkOutput("to_before", {31'b0, err_o}, 32'h0);
    step();
    checkOutput("to_at", {31'b0, err_o}, 32'h1);
    checkOutput("to_still_busy", {31'b0, busy_o}, 32'h1);
    doReset();

    // Back-to-back MUL accepted in the arrive cycle
    applyStimulus(1'b1, 3'd1, 32'h0);
    step();
    mul_valid_i = 1'b1; mul_hi_i = 32'h11; mul_lo_i = 32'h22;
    #1 checkOutput("b2b_nostall", {31'b0, issue_stall_o}, 32'h0);
    step();
    quiet();
    checkOutput("b2b_hi", hi_o, 32'h11);
    checkOutput("b2b_busy", {31'b0, busy_o}, 32'h1);
    mul_valid_i = 1'b1; mul_hi_i = 32'h33; mul_lo_i = 32'h44;
    step();
    quiet();
    checkOutput("b2b_lo2", lo_o, 32'h44);

    // Unexpected strobe in IDLE
    div_valid_i = 1'b1; div_hi_i = 32'h99; div_lo_i = 32'h98;
    step();
    quiet();
    checkOutput("stray_err", {31'b0, err_o}, 32'h1);
    checkOutput("stray_ignored", hi_o, 32'h33);
    doReset();

    // Both strobes in MUL_WAIT: multiplier wins, divider strobe flagged
    applyStimulus(1'b1, 3'd1, 32'h0);
    step();
    quiet();
    mul_valid_i = 1'b1; mul_hi_i = 32'h5A; mul_lo_i = 32'hA5;
    div_valid_i = 1'b1; div_hi_i = 32'h1; div_lo_i = 32'h1;
    step();
    quiet();
    checkOutput("both_hi", hi_o, 32'h5A);
    checkOutput("both_err", {31'b0, err_o}, 32'h1);
    doReset();

    // Test 5: reset during DIV_WAIT, then late divider strobe
    applyStimulus(1'b1, 3'd3, 32'h1357);
    step();
    applyStimulus(1'b1, 3'd2, 32'h0);
    step();
    quiet();
    step();
    rst_ni = 1'b0;
    #2;
    checkOutput("t5_async_busy", {31'b0, busy_o}, 32'h0);
    checkOutput("t5_async_hi", hi_o, 32'h0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    div_valid_i = 1'b1; div_hi_i = 32'h5; div_lo_i = 32'h6;
    step();
    quiet();
    checkOutput("t5_hi", hi_o, 32'h0);
    checkOutput("t5_lo", lo_o, 32'h0);
    checkOutput("t5_busy", {31'b0, busy_o}, 32'h0);
    checkOutput("t5_err", {31'b0, err_o}, 32'h1);
    doReset();

`ifdef MPX_HILO_ABORT_EN
    // Test 6: second MUL drops the first product
    applyStimulus(1'b1, 3'd1, 32'h0);
    step();
    applyStimulus(1'b1, 3'd1, 32'h0);
    #1 checkOutput("t6_nostall", {31'b0, issue_stall_o}, 32'h0);
    step();
    quiet();
    mul_valid_i = 1'b1; mul_lo_i = 32'h5;
    step();
    quiet();
    mul_valid_i = 1'b1; mul_lo_i = 32'h9;
    step();
    quiet();
    checkOutput("t6_lo", lo_o, 32'h9);
    checkOutput("t6_err", {31'b0, err_o}, 32'h0);
    applyStimulus(1'b1, 3'd2, 32'h0);
    step();
    applyStimulus(1'b1, 3'd1, 32'h0);
    #1 checkOutput("t6_abort", {31'b0, div_abort_o}, 32'h1);
    step();
    quiet();
`else
    applyStimulus(1'b1, 3'd2, 32'h0);
    step();
    applyStimulus(1'b1, 3'd1, 32'h0);
    #1;
    checkOutput("noabort_stall", {31'b0, issue_stall_o}, 32'h1);
    checkOutput("noabort_tied", {31'b0, div_abort_o}, 32'h0);
    step();
    quiet();
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
